scan_ctrl: RTL
==============

// Module: scan_ctrl
// PURPOSE
//  Sequences the HUB75 panel datapath: walks the dual-port pixel memory read address, and drives the panel
//  shift clock, latch strobe, output-enable and row select. It also provides the PWM duty counter to the
//  rgb16 decoders. It owns display/write bank double-buffering, with a swap handshake to the SPI writer.
//  Sits between the pixel memories (1-cycle read latency) and the rgb16 decoders / panel pins.
// PARAMETERS
//  ROWLEN     64  pixels shifted per row; COL_BITS = $clog2(ROWLEN)
//  ROW_BITS   4   row-select width; rows per frame = 2**ROW_BITS
//  DUTY_BITS  5   PWM duty counter width (matches 5-bit colour fields)
// PORTS
//  clk        in   1         system clock
//  rst        in   1         synchronous, active-high reset
//  run        in   1         1=scan; 0=stop at next row boundary, panel blanked
//  rd_addr    out  1+ROW_BITS+COL_BITS  {disp_bank,row_shift,col} to both memories
//  pix_load   out  1         rdata valid this cycle; decoder registers rgb at end of cycle
//  duty_cnt   out  DUTY_BITS current PWM compare value
//  sclk_out   out  1         panel shift clock
//  stb        out  1         panel latch
//  oe         out  1         panel blank, 1=off
//  rowsel     out  ROW_BITS  displayed row
//  swap_req   in   1         1-cycle pulse: writer finished filling the write bank
//  swap_ack   out  1         1-cycle pulse: swap applied
//  wr_bank    out  1         bank the writer may fill (= ~disp_bank)
//  frame_start out 1         1-cycle pulse at the start of each PWM period
// BEHAVIOUR
//  Reset: state=SHIFT, slot=0, row_shift=0, oe=1, stb=0, sclk_out=0, pix_load=0, rowsel=0, rd_addr=0,
//   duty_cnt=0, disp_bank=0, swap_pending=0, swap_ack=0, frame_start=0, latched_once=0.
//  SHIFT: ROWLEN+1 slots of 2 cycles, phase A then phase B.
//   - Slot k<ROWLEN, phase A: rd_addr col=k.
//   - Slot k<ROWLEN, phase B: pix_load=1.
//   - Slot k>=1, phase B: sclk_out=1, clocking pixel k-1 with one cycle of setup.
//   - Slot ROWLEN is clock-only; sclk_out pulses exactly ROWLEN times per row.
//   - SHIFT length is 2*(ROWLEN+1) cycles.
//   - oe=0 during SHIFT only once latched_once=1; otherwise oe=1.
//  BLANK: oe=1, 1 cycle.
//  LATCH: stb=1, 1 cycle.
//  ROWADV: stb=0; rowsel<=row_shift; row_shift<=row_shift+1 (wraps); latched_once<=1.
//  GUARD: oe=1, 1 cycle, then SHIFT slot 0 if run=1, else IDLE.
//  Row period = 2*ROWLEN+6 cycles (134 at default).
//  IDLE: oe=1, sclk_out=0. Returns to SHIFT slot 0 on the cycle after run=1. run is ignored mid-row.
//  Frame end is the ROWADV where row_shift wraps to 0: duty_cnt<=duty_cnt+1, wrapping at 2**DUTY_BITS.
//  PWM period end is the frame end where duty_cnt wraps to 0. On that cycle:
//   - frame_start=1;
//   - if swap_pending, or swap_req is high that same cycle: disp_bank toggles, swap_ack=1, pending clears.
//  swap_req at any other time sets swap_pending. swap_req while pending is ignored (no second swap).
//  rd_addr bank bit changes only at a PWM period end, so a period never mixes banks.
//  rst mid-operation: next cycle all outputs take their reset values, and any pending swap is lost.
// CONFIGURATION
//  BRIGHTNESS_EN defined:
//   - adds port bright in COL_BITS+1, global brightness;
//   - during SHIFT, oe=0 only for the first min(2*bright, 2*(ROWLEN+1)) cycles, 1 afterwards;
//   - bright=0 keeps the panel dark;
//   - bright is sampled at SHIFT slot 0.
//  BRIGHTNESS_EN undefined: port absent, oe=0 for the whole of SHIFT (after latched_once).
// TESTING
//  1. Reset release, run=1: cycles 0,2,..,126 show rd_addr col 0..63 with bank=0, row=0. pix_load is high
//     on odd cycles 1..127. sclk_out is high on cycles 3,5,..,129 (64 pulses). oe=1 throughout the first row.
//  2. Row timing: stb=1 only at cycle 131. rowsel=0 from cycle 132, and rowsel=1 after the next row.
//     Row period is 134 cycles. oe=0 during the second row's SHIFT.
//  3. Frame: after 16 ROWADVs, duty_cnt 0->1 and rd_addr row returns to 0. After 32 frames, duty_cnt
//     wraps to 0 and frame_start pulses once.
//  4. Swap: swap_req pulse mid-period -> swap_ack exactly at the period end, rd_addr bank=1, wr_bank=0.
//     A second swap_req while pending gives no extra ack. swap_req coincident with the period end swaps
//     that same cycle.
//  5. run=0 mid-SHIFT: the row completes through GUARD, then IDLE with oe=1 and no sclk. run=1 resumes
//     with col=0 of the next row.
//  6. rst asserted at slot 30: next cycle reset values, scan restarts at row 0 col 0.
//     BRIGHTNESS_EN with bright=10: oe=0 for exactly 20 cycles per row.

Source files
------------

// File: rtl/scan_ctrl.sv
// HUB75 scan sequencer: pixel read walk, shift/latch/blank timing, PWM duty and bank swap.
// Optional global brightness gating of oe when BRIGHTNESS_EN is defined.
module scan_ctrl #(
  parameter int ROWLEN    = 64,
  parameter int ROW_BITS  = 4,
  parameter int DUTY_BITS = 5,
  localparam int COL_BITS = $clog2(ROWLEN),
  localparam int AW       = 1 + ROW_BITS + COL_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
`ifdef BRIGHTNESS_EN
  input  logic [COL_BITS:0]    bright,
`endif
  output logic [AW-1:0]        rd_addr,
  output logic                 pix_load,
  output logic [DUTY_BITS-1:0] duty_cnt,
  output logic                 sclk_out,
  output logic                 stb,
  output logic                 oe,
  output logic [ROW_BITS-1:0]  rowsel,
  input  logic                 swap_req,
  output logic                 swap_ack,
  output logic                 wr_bank,
  output logic                 frame_start
);

  localparam int SW = COL_BITS + 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(ROWLEN);

  typedef enum logic [2:0] {
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_ROWADV,
    ST_GUARD,
    ST_IDLE
  } state_t;

  state_t              state, state_n;
  logic [SW-1:0]       slot, slot_n;
  logic                phase, phase_n;
  logic [ROW_BITS-1:0] row_shift;
  logic                disp_bank;
  logic                swap_pending;
  logic                latched_once;
  logic                shifting;
  logic                frame_end;
  logic                period_end;
  logic                do_swap;

`ifdef BRIGHTNESS_EN
  logic [COL_BITS:0]   bright_q;
  logic [COL_BITS:0]   bright_eff;
  logic [SW:0]         shift_idx;
`endif

  always_comb begin
    state_n = state;
    slot_n  = slot;
    phase_n = phase;
    case (state)
      ST_SHIFT: begin
        phase_n = ~phase;
        if (phase) begin
          slot_n = slot + 1'b1;
          if (slot == SLOT_LAST) begin
            slot_n  = '0;
            state_n = ST_BLANK;
          end
        end
      end
      ST_BLANK:  state_n = ST_LATCH;
      ST_LATCH:  state_n = ST_ROWADV;
      ST_ROWADV: state_n = ST_GUARD;
      ST_GUARD:  state_n = run ? ST_SHIFT : ST_IDLE;
      ST_IDLE:   state_n = run ? ST_SHIFT : ST_IDLE;
      default:   state_n = ST_SHIFT;
    endcase
  end

  assign shifting    = (state == ST_SHIFT);
  assign frame_end   = (state == ST_ROWADV) && (&row_shift);
  assign period_end  = frame_end && (&duty_cnt);
  assign do_swap     = period_end && (swap_pending || swap_req);

  assign rd_addr     = {disp_bank, row_shift, slot[COL_BITS-1:0]};
  assign pix_load    = shifting && phase && (slot != SLOT_LAST);
  assign sclk_out    = shifting && phase && (slot != '0);
  assign stb         = (state == ST_LATCH);
  assign swap_ack    = do_swap;
  assign frame_start = period_end;
  assign wr_bank     = ~disp_bank;

`ifdef BRIGHTNESS_EN
  // slot 0 uses the live value so the sampled brightness applies to the whole row
  assign bright_eff = (slot == '0) ? bright : bright_q;
  assign shift_idx  = {slot, phase};
`endif

  always_comb begin
    oe = 1'b1;
    if (shifting && latched_once) begin
`ifdef BRIGHTNESS_EN
      oe = !(shift_idx < {bright_eff, 1'b0});
`else
      oe = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_SHIFT;
      slot         <= '0;
      phase        <= 1'b0;
      row_shift    <= '0;
      rowsel       <= '0;
      duty_cnt     <= '0;
      disp_bank    <= 1'b0;
      swap_pending <= 1'b0;
      latched_once <= 1'b0;
`ifdef BRIGHTNESS_EN
      bright_q     <= '0;
`endif
    end else begin
      state <= state_n;
      slot  <= slot_n;
      phase <= phase_n;
      if (state == ST_ROWADV) begin
        rowsel       <= row_shift;
        row_shift    <= row_shift + 1'b1;
        latched_once <= 1'b1;
        if (frame_end) duty_cnt <= duty_cnt + 1'b1;
      end
      if (do_swap) begin
        disp_bank    <= ~disp_bank;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
`ifdef BRIGHTNESS_EN
      if (shifting && slot == '0 && !phase) bright_q <= bright;
`endif
    end
  end

endmodule
